// File: rtl/mem_responder_pkg.sv
// Shared memory-bus types: command enum, request bundle, tag width.
// Imported by the caches, the responder and its allocator.
package mem_responder_pkg;

  localparam int TAG_W = 4;
  localparam int IDX_MAX_W = 29;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic                 valid;
    bus_cmd_e             cmd;
    logic [TAG_W-1:0]     tag;
    logic [IDX_MAX_W-1:0] index;
    logic [63:0]          data;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Processor/memory bus: command, address, store data in;
// response tag, load data, completion tag out.
interface mem_responder_if;
  import mem_responder_pkg::*;

  bus_cmd_e         proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag
  );

endinterface

// File: rtl/mem_responder_tags.sv
// Free-tag pool: NUM_TAGS-bit free vector, lowest free tag granted.
// Ports: alloc_req, free_en/free_tag in; grant_tag out (0 = empty).
module tag_allocator
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_req,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] grant_tag
);

  logic [NUM_TAGS-1:0] free_q;
  logic [NUM_TAGS-1:0] free_d;

  // Scan downward so the lowest free tag wins.
  always_comb begin
    grant_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_q[i]) grant_tag = TAG_W'(i + 1);
    end
  end

  // A freed tag only shows up in free_q next cycle,
  // so it is never re-granted in its completion cycle.
  always_comb begin
    free_d = free_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc_req && grant_tag == TAG_W'(i + 1))
        free_d[i] = 1'b0;
      if (free_en && free_tag == TAG_W'(i + 1))
        free_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) free_q <= '1;
    else       free_q <= free_d;
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged fixed-latency memory responder with a LATENCY-deep pipe.
// Ports: clock, reset (sync, high), bus (slave side of the mem bus).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 8,
  parameter int NUM_TAGS  = 15,
  parameter int MEM_WORDS = 8192
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [63:0]      mem_q [MEM_WORDS];
  mem_req_t         pipe_q [LATENCY];
  mem_req_t         pipe_d [LATENCY];
  mem_req_t         fin;
  logic [TAG_W-1:0] grant_tag;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fin_idx;
  logic             req_vld;
  logic             accept;
  logic             free_en;
  logic             st_we;
  logic             ld_out;
  logic             unused_bits;

  assign req_vld = !reset
                && bus.proc2mem_command != BUS_NONE;
  assign accept  = req_vld && grant_tag != '0;
  assign req_idx = bus.proc2mem_addr[IDX_W+2:3];

  assign fin     = pipe_q[LATENCY-1];
  assign fin_idx = fin.index[IDX_W-1:0];
  // In-flight work is dropped while reset is high.
  assign free_en = fin.valid && !reset;
  assign st_we   = free_en && fin.cmd == BUS_STORE;
  assign ld_out  = free_en && fin.cmd == BUS_LOAD;

  assign unused_bits = ^{bus.proc2mem_addr[2:0],
                         bus.proc2mem_addr[31:IDX_W+3],
                         fin.index[IDX_MAX_W-1:IDX_W]};

  tag_allocator #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tags (
    .clock     (clock),
    .reset     (reset),
    .alloc_req (req_vld),
    .free_en   (free_en),
    .free_tag  (fin.tag),
    .grant_tag (grant_tag)
  );

  always_comb begin
    bus.mem2proc_response = accept ? grant_tag : '0;
    bus.mem2proc_tag      = ld_out ? fin.tag : '0;
    bus.mem2proc_data     = ld_out ? mem_q[fin_idx] : '0;
  end

  always_comb begin
    pipe_d[0].valid = accept;
    pipe_d[0].cmd   = bus.proc2mem_command;
    pipe_d[0].tag   = grant_tag;
    pipe_d[0].index = IDX_MAX_W'(req_idx);
    pipe_d[0].data  = bus.proc2mem_data;
    for (int i = 1; i < LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++)
        pipe_q[i].valid <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Stores land at completion, keeping acceptance order.
  always_ff @(posedge clock) begin
    if (st_we) mem_q[fin_idx] <= fin.data;
  end

endmodule
